// File: rtl/bcd_to_binary_if.sv
// rtl/bcd_to_binary_if.sv - start/busy/done handshake bundle for the BCD to binary converter
interface bcd_to_binary_if #(
  parameter int DIGITS = 5,
  parameter int OUT_W  = 17
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [OUT_W-1:0]      bin_out;
  logic                  err_out;

  // Requester side: issues operands and watches for the result
  modport master (
    output start, bcd_in,
    input  busy, done, bin_out, err_out
  );

  // Converter side
  modport slave (
    input  start, bcd_in,
    output busy, done, bin_out, err_out
  );
endinterface

// File: rtl/bcd_to_binary.sv
// rtl/bcd_to_binary.sv - sequential packed-BCD to binary converter, one digit per clock, MSD first
module bcd_to_binary #(
  parameter int DIGITS = 5,
  parameter int OUT_W  = 17
) (
  input  logic             clk,
  input  logic             reset,
  bcd_to_binary_if.slave   bus
);
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t               state;
  state_t               stateNext;
  logic                 accept;
  logic                 finish;
  logic                 busyC;

  logic [4*DIGITS-1:0]  shiftReg;
  logic [OUT_W-1:0]     acc;
  logic [CNT_W-1:0]     cnt;
  logic                 errFlag;
  logic                 doneR;
  logic [OUT_W-1:0]     binR;
  logic                 errR;

  logic [3:0]           digit;
  logic                 digitBad;
  logic [OUT_W-1:0]     accNext;
  logic                 errFinal;

  // The MSD always sits at the top of the shift register; acc*10 is built from two shifts
  assign digit    = shiftReg[4*DIGITS-1 -: 4];
  assign digitBad = (digit > 4'd9);
  assign accNext  = (acc << 3) + (acc << 1) + {{(OUT_W-4){1'b0}}, digit};
  assign errFinal = errFlag | digitBad;

  assign bus.busy    = busyC;
  assign bus.done    = doneR;
  assign bus.bin_out = binR;
  assign bus.err_out = errR;

  // State register; reset wins over everything, so an aborted conversion never completes
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and control decode
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    finish    = 1'b0;
    busyC     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          stateNext = CONV;
        end
      end
      CONV: begin
        busyC = 1'b1;
        if (cnt == LAST) begin
          finish    = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: load on accept, accumulate each CONV edge, publish results only on completion
  always_ff @(posedge clk) begin
    if (reset) begin
      shiftReg <= '0;
      acc      <= '0;
      cnt      <= '0;
      errFlag  <= 1'b0;
      doneR    <= 1'b0;
      binR     <= '0;
      errR     <= 1'b0;
    end else begin
      doneR <= 1'b0;
      if (accept) begin
        shiftReg <= bus.bcd_in;
        acc      <= '0;
        cnt      <= '0;
        errFlag  <= 1'b0;
      end else if (busyC) begin
        acc      <= accNext;
        shiftReg <= shiftReg << 4;
        cnt      <= cnt + CNT_W'(1);
        if (digitBad) begin
          errFlag <= 1'b1;
        end
        if (finish) begin
          doneR <= 1'b1;
          errR  <= errFinal;
          binR  <= errFinal ? '0 : accNext;
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_to_binary.sv
// tb/tb_bcd_to_binary.sv - scoreboard bench for the BCD to binary converter
module tb_bcd_to_binary;
  logic clk = 1'b0;
  logic reset;
  int   testsRun = 0;
  int   testsFailed = 0;
  int   doneCount = 0;
  int   pushCount = 0;
  logic [17:0] expQ[$];

  bcd_to_binary_if #(.DIGITS(5), .OUT_W(17)) bus();

  bcd_to_binary #(.DIGITS(5), .OUT_W(17)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {err, bin}
  function automatic logic [17:0] model(input logic [19:0] b);
    logic [16:0] a;
    logic        e;
    logic [3:0]  d;
    a = '0;
    e = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      d = b[4*k +: 4];
      if (d > 4'd9) e = 1'b1;
      a = a * 17'd10 + {13'd0, d};
    end
    return {e, e ? 17'd0 : a};
  endfunction

  // Scoreboard: every done must match the oldest expected result
  always @(negedge clk) begin
    logic [17:0] e;
    if (!reset && bus.done) begin
      doneCount++;
      if (expQ.size() == 0) begin
        checkVal("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkVal("bin_out", {15'd0, bus.bin_out}, {15'd0, e[16:0]});
        checkVal("err_out", {31'd0, bus.err_out}, {31'd0, e[17]});
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge where done is high
  task automatic runConv(input logic [19:0] bcd, input bit scramble);
    logic [16:0] prevBin;
    prevBin = bus.bin_out;
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    expQ.push_back(model(bcd));
    pushCount++;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkVal($sformatf("busy_c%0d", i), {31'd0, bus.busy}, 32'd1);
      checkVal($sformatf("nodone_c%0d", i), {31'd0, bus.done}, 32'd0);
      checkVal($sformatf("hold_c%0d", i), {15'd0, bus.bin_out}, {15'd0, prevBin});
      if (scramble) bus.bcd_in = 20'($urandom);
      @(negedge clk);
    end
    checkVal("done_pulse", {31'd0, bus.done}, 32'd1);
    checkVal("busy_end", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!bus.done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    if (!bus.done) checkVal("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    int dc;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkVal("rst_busy", {31'd0, bus.busy}, 32'd0);
    checkVal("rst_done", {31'd0, bus.done}, 32'd0);
    checkVal("rst_bin", {15'd0, bus.bin_out}, 32'd0);
    checkVal("rst_err", {31'd0, bus.err_out}, 32'd0);
    @(negedge clk);

    runConv(20'h12345, 1'b0);
    @(negedge clk);
    runConv(20'h99999, 1'b0);
    @(negedge clk);
    runConv(20'h00000, 1'b0);
    @(negedge clk);
    runConv(20'h12A45, 1'b0);
    @(negedge clk);
    runConv(20'h00007, 1'b0);
    @(negedge clk);

    // Start while busy is ignored; start in the done cycle is accepted
    bus.start  = 1'b1;
    bus.bcd_in = 20'h00321;
    expQ.push_back(model(20'h00321));
    pushCount++;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 20'h55555;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(cyc);
    checkVal("ignored_start_latency", cyc, 32'd3);
    runConv(20'h00042, 1'b0);
    @(negedge clk);

    // Reset mid-conversion aborts without a done
    bus.start  = 1'b1;
    bus.bcd_in = 20'h54321;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkVal("abort_busy", {31'd0, bus.busy}, 32'd0);
    checkVal("abort_bin", {15'd0, bus.bin_out}, 32'd0);
    checkVal("abort_err", {31'd0, bus.err_out}, 32'd0);
    dc = doneCount;
    repeat (10) @(negedge clk);
    checkVal("abort_no_done", dc, doneCount);
    runConv(20'h54321, 1'b0);
    @(negedge clk);

    runConv(20'h01000, 1'b1);
    repeat (3) @(negedge clk);

    checkVal("queue_empty", expQ.size(), 32'd0);
    checkVal("done_count", doneCount, pushCount);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
Sequential converter from packed BCD to unsigned binary. It is the inverse of the datapath's binary-to-BCD stage. It takes a 5-digit packed BCD operand, such as a keyed-in or display-echoed value, and produces the 17-bit binary value that the execution datapath consumes. It converts one digit per clock, most significant digit first, using a start/busy/done handshake. Invalid BCD digits are flagged so the caller can raise the calculator error indication.

Parameters:
DIGITS, 5, number of BCD digits in bcd_in (4 bits each).
OUT_W, 17, binary result width; must satisfy 2^OUT_W > 10^DIGITS - 1.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request a conversion; sampled only while idle (busy=0).
bcd_in  input  4*DIGITS  packed BCD operand; digit k is bcd_in[4k+3:4k], digit DIGITS-1 is the MSD; sampled only on the accepting edge.
busy  output  1  conversion in progress.
done  output  1  single-cycle pulse; bin_out and err_out are valid from this cycle on.
bin_out  output  OUT_W  binary result; held until the next done.
err_out  output  1  last conversion saw a digit > 9; held until the next done.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - FSM goes to IDLE.
  - busy=0, done=0, bin_out=0, err_out=0.
  - Internal accumulator, digit counter and error flag are cleared.
  - Reset has priority over start and over any conversion in progress; an aborted conversion never produces a done.
- FSM states: IDLE, CONV.
- IDLE:
  - On an edge with start=1: latch bcd_in into a shift register, clear acc=0, cnt=0, clear the internal error flag, set busy=1, go to CONV.
  - With start=0: hold. done stays 0 except for the pulse defined below.
- CONV, per edge:
  - d = current MSD of the shift register.
  - acc <= acc*10 + d, computed as (acc<<3)+(acc<<1)+d at OUT_W bits.
  - Shift the register left by 4; cnt <= cnt+1.
  - If d > 9: set the sticky error flag. The accumulate still executes; the result is discarded below.
- Completion, on the edge processing digit index cnt = DIGITS-1:
  - Go to IDLE, busy <= 0, done <= 1 for exactly one cycle.
  - err_out <= error flag OR (last digit > 9).
  - bin_out <= 0 if that error is set; otherwise bin_out <= final acc.
- Latency:
  - start is accepted at edge E0; digits are processed at edges E1..E_DIGITS.
  - done=1 and busy=0 in the cycle after edge E_DIGITS, i.e. DIGITS clocks after acceptance.
  - busy=1 for exactly DIGITS cycles.
- start while busy=1 is ignored and not queued.
- start=1 in the same cycle done=1: accepted, because the FSM is already in IDLE. This allows back-to-back conversions with a throughput of one per DIGITS+1 cycles.
- bcd_in may change freely after the accepting edge without affecting the conversion.
- bin_out and err_out change only on a done edge or on reset, never mid-conversion.
- Overflow cannot occur given the OUT_W constraint; no saturation logic is needed.
- Leading zero digits are legal and produce no special behaviour.

Test Plan:
- After reset, pulse start with bcd_in=20'h12345 -> busy high 5 cycles, then done pulse for 1 cycle with bin_out=17'd12345 (0x03039), err_out=0.
- bcd_in=20'h99999 -> bin_out=17'd99999 (0x1869F), err_out=0. Then bcd_in=20'h00000 -> bin_out=0, err_out=0.
- bcd_in=20'h12A45 (invalid middle digit) -> done after 5 cycles with err_out=1, bin_out=0. A following conversion of 20'h00007 -> err_out=0, bin_out=7.
- Start 20'h00321, then pulse start with 20'h55555 two cycles later while busy -> second start ignored; done with bin_out=321. Start asserted during the done cycle with 20'h00042 -> accepted, next done with bin_out=42.
- Start 20'h54321, assert reset at the 3rd busy cycle -> next cycle busy=0, bin_out=0, err_out=0, and no done pulse follows. A fresh start of 20'h54321 -> bin_out=54321.
- Change bcd_in every cycle after an accepted start of 20'h01000 -> bin_out=1000, unaffected by the changes.
